// File: rtl/rotate_left_seq.sv
// Multi-cycle rotate-left unit: latches A/rotate on start and rotates one bit per clock.
// Optional ROTL_FAST_EN: rotate by 4 per clock while at least 4 positions remain.
module rotate_left_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] rotate,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_rot;
    logic [CNT_W-1:0] cnt, step;
    logic             accept, last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == step);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

`ifdef ROTL_FAST_EN
    always_comb begin
        if (cnt >= CNT_W'(4)) begin
            step     = CNT_W'(4);
            work_rot = {work[WIDTH-5:0], work[WIDTH-1:WIDTH-4]};
        end else begin
            step     = CNT_W'(1);
            work_rot = {work[WIDTH-2:0], work[WIDTH-1]};
        end
    end
`else
    assign step     = CNT_W'(1);
    assign work_rot = {work[WIDTH-2:0], work[WIDTH-1]};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (rotate == '0) ? DONE : RUN;
            RUN:  if (last)  state_nx = DONE;
            DONE: begin
                if (start) state_nx = (rotate == '0) ? DONE : RUN;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Operand and remaining count; A/rotate are ignored outside the accepting edge.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            work <= A;
            cnt  <= rotate;
        end else if (state == RUN) begin
            work <= work_rot;
            cnt  <= cnt - step;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            Result <= '0;
        else if (accept && rotate == '0)
            Result <= A;
        else if (state == RUN && last)
            Result <= work_rot;
    end

endmodule

// File: tb/tb_rotate_left_seq.sv
// Scoreboard bench for rotate_left_seq: driver pushes expected result/done-edge, monitor checks.
module tb_rotate_left_seq;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [4:0]  rotate = '0;
    logic        busy, done;
    logic [31:0] Result;

    rotate_left_seq dut (
        .clock(clock), .clear_n(clear_n), .start(start), .A(A), .rotate(rotate),
        .busy(busy), .done(done), .Result(Result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          edge_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_res = '0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
        logic [63:0] t;
        t = {a, a} << n;
        return t[63:32];
    endfunction

    function automatic int lat(input int n);
`ifdef ROTL_FAST_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    // Called at a negedge with the DUT idle or in DONE; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input int n, input logic [31:0] res);
        exp_t e;
        A = a; rotate = n[4:0]; start = 1'b1;
        @(posedge clock);
        #1;
        e.res = res;
        e.due = edge_cnt + lat(n);
        q.push_back(e);
        start = 1'b0;
        A = $urandom;
        rotate = 5'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clock);
        while (!done && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (!done) chk("done_timeout", {31'b0, done}, 32'd1);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!clear_n) begin
            q.delete();
            exp_res = '0;
        end else begin
            chk("busy", {31'b0, busy}, {31'b0, (q.size() > 0 && q[0].due > edge_cnt)});
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", {31'b0, done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", Result, e.res);
                    chk("done_edge", 32'(edge_cnt), 32'(e.due));
                    exp_res = e.res;
                end
            end else begin
                chk("result_hold", Result, exp_res);
            end
        end
    end

    logic [31:0] dir_a   [7] = '{32'hA5A5A5A5, 32'hDEADBEEF, 32'h12345678, 32'h87654321,
                                 32'h80000000, 32'h00000001, 32'hCAFEF00D};
    int          dir_n   [7] = '{1, 2, 8, 16, 31, 31, 0};
    // 80000000 rotl 31 is the same as a rotate right by 1
    logic [31:0] dir_res [7] = '{32'h4B4B4B4B, 32'h7AB6FBBF, 32'h34567812, 32'h43218765,
                                 32'h40000000, 32'h80000000, 32'hCAFEF00D};

    initial begin
        logic [31:0] ra;
        int          rn;
        repeat (2) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", Result, 32'd0);
        #1 clear_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            issue(dir_a[i], dir_n[i], dir_res[i]);
            wait_done();
            @(negedge clock);
        end

        // back-to-back starts issued in the DONE cycle
        issue(32'h0F0F1234, 4, 32'hF0F12340);
        wait_done();
        issue(32'h13579BDF, 0, 32'h13579BDF);
        wait_done();
        issue(32'h89ABCDEF, 12, 32'hBCDEF89A);
        wait_done();
        @(negedge clock);

        // start pulse during RUN must be ignored
        ra = $urandom;
        rn = 24 + $urandom_range(0, 7);
        issue(ra, rn, rotl(ra, rn));
        repeat (2) @(negedge clock);
        start = 1'b1; A = $urandom; rotate = 5'($urandom);
        @(negedge clock);
        start = 1'b0;
        wait_done();
        @(negedge clock);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rn = $urandom_range(0, 31);
            issue(ra, rn, rotl(ra, rn));
            wait_done();
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        @(negedge clock);

        // abort mid-RUN: outputs clear at once and no done ever follows
        issue(32'hDEADBEEF, 9, 32'h0);
        repeat (3) @(negedge clock);
        #2 clear_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", Result, 32'd0);
        @(negedge clock);
        #1 clear_n = 1'b1;
        repeat (20) @(negedge clock);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
